// File: rtl/fc_pkg.sv
// Shared types and constants for the fully-connected activation loader.
// Defaults match the 84-input, 8-bit activation layer.
package fc_pkg;

    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } bank_state_t;

    localparam int FC_WIDTH = 8;
    localparam int FC_IN    = 84;
    localparam int FC_SHIFT = 8;
    localparam int FC_IN_W  = FC_WIDTH * 2 + $clog2(FC_IN);
    localparam int FC_CNT_W = $clog2(FC_IN + 1);

    function automatic int act_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

    localparam int ACT_MAX = act_max(FC_WIDTH);

endpackage

// File: rtl/fc_requant.sv
// Requantizer: arithmetic right shift, then clamp to the
// non-negative half of the signed WIDTH range.
module fc_requant
    import fc_pkg::*;
#(
    parameter int IN_W  = FC_IN_W,
    parameter int WIDTH = FC_WIDTH,
    parameter int SHIFT = FC_SHIFT
) (
    input  logic [IN_W-1:0]  data,
    output logic [WIDTH-1:0] act
);

    localparam logic signed [IN_W-1:0] LIM = IN_W'(act_max(WIDTH));

    logic signed [IN_W-1:0] s;

    always_comb begin
        s = $signed(data) >>> SHIFT;
        if (s < 0) begin
            act = '0;
        end else if (s > LIM) begin
            act = WIDTH'(LIM);
        end else begin
            act = s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fc_act_loader.sv
// Streaming activation loader packing requantized results into x[0:IN-1].
// Define FC_ACT_LOADER_DBUF_EN for two ping-pong fill banks.
module fc_act_loader
    import fc_pkg::*;
#(
    parameter int WIDTH = FC_WIDTH,
    parameter int IN    = FC_IN,
    parameter int IN_W  = FC_IN_W,
    parameter int SHIFT = FC_SHIFT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [IN_W-1:0]          in_data,
    input  logic                     in_last,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         x [0:IN-1],
    output logic [$clog2(IN+1)-1:0]  count,
    output logic                     frame_err
);

    localparam int CW = $clog2(IN + 1);
`ifdef FC_ACT_LOADER_DBUF_EN
    localparam int   NB = 2;
    localparam logic DB = 1'b1;
`else
    localparam int   NB = 1;
    localparam logic DB = 1'b0;
`endif

    logic [WIDTH-1:0] bank [NB][IN];
    bank_state_t      st [NB];
    logic             wr;
    logic             rd;
    logic [CW-1:0]    idx;
    logic [WIDTH-1:0] elem;
    logic             accept;
    logic             is_end;
    logic             complete;
    logic             rel;
    logic             oth;

    fc_requant #(
        .IN_W  (IN_W),
        .WIDTH (WIDTH),
        .SHIFT (SHIFT)
    ) u_requant (
        .data (in_data),
        .act  (elem)
    );

    // Frames alternate banks in order, so wr/rd act as a 2-entry FIFO.
    assign out_valid = (st[rd] == FULL);
    assign in_ready  = (st[wr] == FILL);
    assign accept    = in_valid && in_ready;
    assign is_end    = (idx == CW'(IN - 1));
    assign complete  = accept && is_end;
    assign rel       = out_valid && out_ready;
    assign oth       = rd ^ DB;
    assign count     = idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr        <= 1'b0;
            rd        <= 1'b0;
            idx       <= '0;
            frame_err <= 1'b0;
            for (int b = 0; b < NB; b++) begin
                st[b] <= FILL;
                for (int i = 0; i < IN; i++) begin
                    bank[b][i] <= '0;
                end
            end
            for (int i = 0; i < IN; i++) begin
                x[i] <= '0;
            end
        end else begin
            frame_err <= 1'b0;
            if (accept) begin
                bank[wr][idx] <= elem;
                if (is_end) begin
                    idx       <= '0;
                    st[wr]    <= FULL;
                    wr        <= wr ^ DB;
                    frame_err <= !in_last;
                end else if (in_last) begin
                    idx       <= '0;
                    frame_err <= 1'b1;
                end else begin
                    idx <= idx + CW'(1);
                end
            end
            if (rel) begin
                st[rd] <= FILL;
                rd     <= rd ^ DB;
            end
            // The last element bypasses the bank so x is valid with out_valid.
            if (complete && (!out_valid || rel)) begin
                for (int i = 0; i < IN - 1; i++) begin
                    x[i] <= bank[wr][i];
                end
                x[IN-1] <= elem;
            end else if (rel && DB && st[oth] == FULL) begin
                for (int i = 0; i < IN; i++) begin
                    x[i] <= bank[oth][i];
                end
            end
        end
    end

endmodule

// File: tb/tb_fc_act_loader.sv
// Self-checking bench for fc_act_loader: vector table, directed
// framing/reset sequences and randomized traffic against a frame-queue model.
module tb_fc_act_loader;
    import fc_pkg::*;

    localparam int W  = 8;
    localparam int N  = 84;
    localparam int IW = 23;
    localparam int SH = 8;
`ifdef FC_ACT_LOADER_DBUF_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    typedef logic [N*W-1:0] frame_t;
    typedef struct {
        logic [IW-1:0] d;
        logic [W-1:0]  e;
    } rq_vec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_data = '0;
    logic          in_last = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  x [0:N-1];
    logic [6:0]    count;
    logic          frame_err;

    int errors = 0;
    int checks = 0;

    frame_t pend[$];
    frame_t fillv;
    frame_t mx;
    int     midx;
    bit     mferr;
    rq_vec_t tv [12];

    always #5 clk = ~clk;

    fc_act_loader #(
        .WIDTH (W),
        .IN    (N),
        .IN_W  (IW),
        .SHIFT (SH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .count     (count),
        .frame_err (frame_err)
    );

    function automatic logic [W-1:0] rq(input logic [IW-1:0] d);
        int s;
        s = int'($signed(d));
        s = s >>> SH;
        if (s < 0) return '0;
        if (s > 127) return 8'd127;
        return W'(s);
    endfunction

    function automatic logic [IW-1:0] rnd_data();
        logic [IW-1:0] d;
        case ($urandom_range(0, 3))
            0: d = IW'($urandom);
            1: d = IW'($urandom_range(0, 32767));
            2: d = IW'($urandom_range(32512, 33024));
            default: d = IW'(-int'($urandom_range(1, 5000)));
        endcase
        return d;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_x(input string nm, input frame_t e);
        int bad;
        bad = -1;
        for (int i = 0; i < N; i++) begin
            if (x[i] !== e[i*W +: W] && bad < 0) bad = i;
        end
        checks++;
        if (bad >= 0) begin
            errors++;
            $display("FAIL %s: x[%0d] got %0d expected %0d at %0t",
                     nm, bad, x[bad], e[bad*W +: W], $time);
        end
    endtask

    task automatic check_all();
        chk("count", int'(count), midx);
        chk("out_valid", int'(out_valid), int'(pend.size() > 0));
        chk("in_ready", int'(in_ready), int'(pend.size() < NB));
        chk("frame_err", int'(frame_err), int'(mferr));
        chk_x("x", mx);
    endtask

    task automatic model_reset();
        pend.delete();
        midx  = 0;
        mferr = 1'b0;
        mx    = '0;
        fillv = '0;
    endtask

    task automatic step(input bit v, input logic [IW-1:0] d, input bit last,
                        input bit ordy, output bit acc);
        bit rel;
        in_valid  = v;
        in_data   = d;
        in_last   = last;
        out_ready = ordy;
        acc = v && (pend.size() < NB);
        rel = ordy && (pend.size() > 0);
        @(posedge clk);
        #1;
        mferr = 1'b0;
        if (rel) void'(pend.pop_front());
        if (acc) begin
            fillv[midx*W +: W] = rq(d);
            if (midx == N - 1) begin
                pend.push_back(fillv);
                midx  = 0;
                mferr = !last;
            end else if (last) begin
                midx  = 0;
                mferr = 1'b1;
            end else begin
                midx++;
            end
        end
        if (pend.size() > 0) mx = pend[0];
        check_all();
    endtask

    task automatic beat(input logic [IW-1:0] d, input bit last, input bit ordy);
        bit acc;
        int n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 300) begin
            step(1'b1, d, last, ordy, acc);
            n++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL beat_timeout: accepted 0 required 1 at %0t", $time);
        end
    endtask

    task automatic frame(input int n, input int last_at, input bit ordy);
        for (int i = 0; i < n; i++) begin
            beat(rnd_data(), i == last_at, ordy);
        end
    endtask

    task automatic idle(input int n, input bit ordy);
        bit acc;
        for (int i = 0; i < n; i++) begin
            step(1'b0, '0, 1'b0, ordy, acc);
        end
    endtask

    initial begin
        bit acc;
        bit last;
        tv[0]  = '{23'h003400, 8'd52};
        tv[1]  = '{23'h010000, 8'd127};
        tv[2]  = '{23'h7FFF00, 8'd0};
        tv[3]  = '{23'h0000FF, 8'd0};
        tv[4]  = '{23'h000100, 8'd1};
        tv[5]  = '{23'h007E80, 8'd126};
        tv[6]  = '{23'h007F00, 8'd127};
        tv[7]  = '{23'h007FFF, 8'd127};
        tv[8]  = '{23'h008000, 8'd127};
        tv[9]  = '{23'h3FFFFF, 8'd127};
        tv[10] = '{23'h400000, 8'd0};
        tv[11] = '{23'h7FFFFF, 8'd0};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Reset in the middle of a frame.
        frame(40, -1, 1'b0);
        rst_n = 1'b0;
        #2;
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        frame(N, N - 1, 1'b0);
        idle(3, 1'b0);
        idle(1, 1'b1);
        idle(1, 1'b0);

        // Requantization table leads a frame.
        for (int i = 0; i < 12; i++) begin
            beat(tv[i].d, 1'b0, 1'b0);
        end
        frame(N - 12, N - 13, 1'b0);
        for (int i = 0; i < 12; i++) begin
            chk($sformatf("requant_%0d", i), int'(x[i]), int'(tv[i].e));
        end
        idle(1, 1'b1);

        // Early last, then a clean frame.
        frame(11, 10, 1'b0);
        frame(N, N - 1, 1'b0);
        idle(1, 1'b1);

        // Missing last still completes the frame.
        frame(N, -1, 1'b0);
        idle(2, 1'b0);
        idle(1, 1'b1);

`ifdef FC_ACT_LOADER_DBUF_EN
        // Two frames fill both banks; a third cannot start.
        frame(N, N - 1, 1'b0);
        frame(N, N - 1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, rnd_data(), 1'b0, 1'b0, acc);
        end
        idle(1, 1'b1);
        idle(1, 1'b1);
        // Completion coinciding with a release.
        frame(N, N - 1, 1'b0);
        frame(N - 1, -1, 1'b0);
        beat(rnd_data(), 1'b1, 1'b1);
        idle(1, 1'b0);
        idle(2, 1'b1);
`endif

        // Randomized traffic with occasional framing errors.
        for (int c = 0; c < 2500; c++) begin
            last = (midx == N - 1) ^ ($urandom_range(0, 99) == 0);
            step($urandom_range(0, 3) != 0, rnd_data(), last,
                 $urandom_range(0, 2) == 0, acc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fc_act_loader.md
# fc_act_loader

Streaming activation loader feeding a fully-connected layer's parallel input vector. Accepts one wide neuron result per beat from the previous layer, requantizes it (arithmetic right shift, clamp to non-negative signed WIDTH range), and packs IN results into the `x[0:IN-1]` array. It then presents the full vector to the combinational `layer` with a valid/ready handshake. It sits between the previous layer's neuron outputs and the next layer's `x` input.

## Interface
- `WIDTH`, 8: activation width of `x` elements.
- `IN`, 84: elements per frame (next layer's fan-in).
- `IN_W`, 23: width of incoming results (`WIDTH*2+$clog2(IN)` of the producing layer).
- `SHIFT`, 8: requantization right-shift amount.
- Reset is asynchronous and active-low; one clock.
- `clk`: input, 1 bit. Sole clock; all state on the rising edge.
- `rst_n`: input, 1 bit. Asynchronous, active-low reset.
- `in_valid`: input, 1 bit. Input beat valid.
- `in_ready`: output, 1 bit. Loader can accept a beat.
- `in_data`: input, `IN_W` bits. Signed result from the previous layer.
- `in_last`: input, 1 bit. Marks the final beat of a frame.
- `out_valid`: output, 1 bit. `x` holds a complete frame.
- `out_ready`: input, 1 bit. Consumer has taken the frame.
- `x[0:IN-1]`: output, `WIDTH` bits each. Packed activation vector.
- `count`: output, `$clog2(IN+1)` bits. Elements written into the fill bank.
- `frame_err`: output, 1 bit. One-cycle pulse on a framing error.

## Operation
- Accept occurs when `in_valid && in_ready`. The requantized value is written to the fill bank at `x[idx]`, and `idx` increments.
- Requantization:
  - `s = $signed(in_data) >>> SHIFT`.
  - If `s < 0`, the element is 0.
  - If `s > 2^(WIDTH-1)-1`, the element is `2^(WIDTH-1)-1`.
  - Otherwise the element is `s[WIDTH-1:0]`.
- Fill-bank states:
  - FILL → FULL on an accept with `idx == IN-1`. `idx` returns to 0.
  - FULL → FILL on `out_valid && out_ready`, or on hand-off in double-buffer mode.
- Framing rules:
  - `in_last` on an accept with `idx != IN-1` (early last): `frame_err` pulses, the partial frame is discarded, `idx` becomes 0, and there is no state change.
  - `in_last` low on the accept with `idx == IN-1`: the frame still completes and `frame_err` pulses.
- A `frame_err` pulse never asserts `out_valid`.
- `x` holds its value while `out_valid` is high. It changes only when a new frame is presented.
- Reset values:
  - `out_valid` = 0, `count` = 0, `frame_err` = 0.
  - All `x` elements = 0.
  - `idx` = 0, and all banks in FILL.
  - Reset takes effect immediately in any state; a partial frame is lost.

## Timing
- Element latency: an accept in cycle N lands in the bank register at edge N+1.
- Frame latency: the final accept in cycle N gives `out_valid` = 1 from cycle N+1. `x` is stable in that same cycle.
- `in_ready` is a combinational decode of registered state only. It never depends on `in_valid` or `out_ready`.
- Single buffer: `in_ready = !out_valid`. A release in cycle M gives `in_ready` = 1 from cycle M+1, so there are no accepts during the release cycle.
- `out_valid` stays high until a cycle with `out_ready` = 1. It falls at the next edge unless another frame is pending (double-buffer mode only).
- `count` reflects accepts up to the previous edge.

## Configuration
- `FC_ACT_LOADER_DBUF_EN` defined:
  - Two banks, A and B. While one bank is presented on `x`, the other fills.
  - `in_ready = 0` only when both banks are FULL.
  - When the presented bank is released and the other bank is FULL, `x` switches to it at the same edge and `out_valid` stays 1.
  - A frame completing in the same cycle as a release is presented at the next edge without a bubble.
  - Frames emerge in acceptance order.
- `FC_ACT_LOADER_DBUF_EN` undefined: single bank; behaviour as above.

## Structure
- Package `fc_pkg` holds:
  - the bank state enum (FILL, FULL);
  - `localparam` helpers for `IN_W` and the count width;
  - the saturation limit constant `ACT_MAX = 2^(WIDTH-1)-1`.
- Sub-module `fc_requant`: combinational shift-and-clamp, `IN_W` in, `WIDTH` out, parameters `SHIFT` and `WIDTH`. It is instantiated once at the input port.

## Test plan
All scenarios use WIDTH=8, IN=84, SHIFT=8.

1. **Reset state:** pulse `rst_n` low mid-frame after 40 accepts → `count` = 0, `out_valid` = 0, all `x` = 0, `in_ready` = 1. A following full frame completes normally.
2. **Requant:** beats 0x003400, 0x010000, -256, 0x0000FF → `x` = 52, 127, 0, 0.
3. **Full frame:** 84 beats with `in_last` on beat 83 and `out_ready` held low → `out_valid` rises the cycle after beat 83 and `in_ready` = 0. Raise `out_ready` for 1 cycle → `out_valid` = 0 and `in_ready` = 1 the next cycle.
4. **Early last:** `in_last` on beat 10 → `frame_err` 1-cycle pulse, `count` = 0, `out_valid` stays 0. The next 84 beats form a valid frame.
5. **Missing last:** 84 beats without `in_last` → frame presented and `frame_err` pulses once.
6. **Double buffer** (`FC_ACT_LOADER_DBUF_EN`): stream 3 frames back-to-back with `out_ready` low → `in_ready` drops only after frame 2 completes. Release frames one per cycle → `out_valid` stays 1 through both hand-offs and `x` shows frame 1 then frame 2 in order.
